// File: rtl/udp_tx_if.sv
// udp_tx_if: handshake bundle for the UDP transmit framer.
//   start_*     : per-packet request (ports and payload length) plus reject pulse
//   in_*        : payload byte stream into the framer
//   out_*       : framed byte stream toward the IP/MAC transmit path
// Modports:
//   slave  - used by the framer itself
//   master - used by the client that issues requests and consumes frames
interface udp_tx_if;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [15:0] payload_len;
  logic        start_rej;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;

  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport slave (
    input  start_valid, src_port, dst_port, payload_len,
    input  in_data, in_valid, in_last, out_ready,
    output start_ready, start_rej, in_ready, out_data, out_valid, out_last
  );

  modport master (
    output start_valid, src_port, dst_port, payload_len,
    output in_data, in_valid, in_last, out_ready,
    input  start_ready, start_rej, in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/udp_tx.sv
// udp_tx: UDP transmit framer.
// Accepts a request (src_port, dst_port, payload_len), emits an 8-byte UDP
// header (checksum always 0x0000) followed by payload_len payload bytes taken
// from the input byte stream. Requests longer than MAX_PAYLOAD are dropped
// with a one-cycle start_rej pulse.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   bus        - udp_tx_if.slave: request, payload-in and frame-out handshakes
//   busy       - high whenever the framer is not idle
//   pkt_count  - packets whose last byte completed its output handshake (wraps)
//   len_err    - one-cycle pulse on in_last / length mismatch
// Optional feature, macro UDP_TX_LEN_CHECK_EN:
//   defined   - in_last is checked; an early last pads with 0x00 (PAD state),
//               a late last discards input through the next in_last (DRAIN).
//   undefined - packets end by byte count only, in_last ignored, len_err = 0.
module udp_tx #(
  parameter int MAX_PAYLOAD = 1472,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  udp_tx_if.slave            bus,
  output logic               busy,
  output logic [COUNT_W-1:0] pkt_count,
  output logic               len_err
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

`ifdef UDP_TX_LEN_CHECK_EN
  typedef enum logic [2:0] {IDLE, HEADER, DATA, PAD, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
`endif

  state_t             state_q, state_d;
  logic [15:0]        src_q, src_d;
  logic [15:0]        dst_q, dst_d;
  logic [15:0]        len_field_q, len_field_d;   // payload length + 8
  logic [2:0]         hdr_cnt_q, hdr_cnt_d;
  logic [15:0]        rem_q, rem_d;               // payload bytes still to emit
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               start_rej_q, start_rej_d;
  logic [COUNT_W-1:0] pkt_count_q, pkt_count_d;
`ifdef UDP_TX_LEN_CHECK_EN
  logic               len_err_q, len_err_d;
`else
  logic               unused_in_last;
  assign unused_in_last = bus.in_last;
`endif

  logic       load_ok;
  logic       start_ready;
  logic       in_ready;
  logic [7:0] hdr_byte;

  // The output register may take a new byte when empty or being drained.
  assign load_ok = !out_valid_q || bus.out_ready;

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_cnt_q)
      3'd0: hdr_byte = src_q[15:8];
      3'd1: hdr_byte = src_q[7:0];
      3'd2: hdr_byte = dst_q[15:8];
      3'd3: hdr_byte = dst_q[7:0];
      3'd4: hdr_byte = len_field_q[15:8];
      3'd5: hdr_byte = len_field_q[7:0];
      default: hdr_byte = 8'h00;  // checksum bytes
    endcase
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_field_d = len_field_q;
    hdr_cnt_d   = hdr_cnt_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    start_rej_d = 1'b0;
    pkt_count_d = pkt_count_q;
`ifdef UDP_TX_LEN_CHECK_EN
    len_err_d   = 1'b0;
`endif
    start_ready = 1'b0;
    in_ready    = 1'b0;

    // Consumption of the current output byte; a load below overrides it.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      if (out_last_q) begin
        pkt_count_d = pkt_count_q + COUNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (bus.start_valid) begin
          if (bus.payload_len > MAX_LEN) begin
            start_rej_d = 1'b1;
          end else begin
            src_d       = bus.src_port;
            dst_d       = bus.dst_port;
            len_field_d = bus.payload_len + 16'd8;
            hdr_cnt_d   = 3'd0;
            state_d     = HEADER;
            // Header byte 0 goes out on the accept edge so it is visible the
            // very next cycle; if the output is still stalled, HEADER sends it.
            if (load_ok) begin
              out_data_d  = bus.src_port[15:8];
              out_valid_d = 1'b1;
              out_last_d  = 1'b0;
              hdr_cnt_d   = 3'd1;
            end
          end
        end
      end

      HEADER: begin
        if (load_ok) begin
          out_data_d  = hdr_byte;
          out_valid_d = 1'b1;
          out_last_d  = (hdr_cnt_q == 3'd7) && (len_field_q == 16'd8);
          hdr_cnt_d   = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == 3'd7) begin
            if (len_field_q == 16'd8) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              rem_d   = len_field_q - 16'd8;
            end
          end
        end
      end

      DATA: begin
        in_ready = load_ok;
        if (bus.in_valid && load_ok) begin
          out_data_d  = bus.in_data;
          out_valid_d = 1'b1;
          out_last_d  = (rem_q == 16'd1);
          rem_d       = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
`ifdef UDP_TX_LEN_CHECK_EN
            if (bus.in_last) begin
              state_d = IDLE;
            end else begin
              state_d   = DRAIN;
              len_err_d = 1'b1;
            end
`else
            state_d = IDLE;
`endif
          end
`ifdef UDP_TX_LEN_CHECK_EN
          else if (bus.in_last) begin
            state_d   = PAD;
            len_err_d = 1'b1;
          end
`endif
        end
      end

`ifdef UDP_TX_LEN_CHECK_EN
      PAD: begin
        if (load_ok) begin
          out_data_d  = 8'h00;
          out_valid_d = 1'b1;
          out_last_d  = (rem_q == 16'd1);
          rem_d       = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) begin
          state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_field_q <= '0;
      hdr_cnt_q   <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      start_rej_q <= 1'b0;
      pkt_count_q <= '0;
`ifdef UDP_TX_LEN_CHECK_EN
      len_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_field_q <= len_field_d;
      hdr_cnt_q   <= hdr_cnt_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      start_rej_q <= start_rej_d;
      pkt_count_q <= pkt_count_d;
`ifdef UDP_TX_LEN_CHECK_EN
      len_err_q   <= len_err_d;
`endif
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.start_rej   = start_rej_q;
  assign bus.in_ready    = in_ready;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign busy            = (state_q != IDLE);
  assign pkt_count       = pkt_count_q;
`ifdef UDP_TX_LEN_CHECK_EN
  assign len_err         = len_err_q;
`else
  assign len_err         = 1'b0;
`endif

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: self-checking bench for udp_tx. Random ports/payloads are framed
// by a queue-based reference model (header bytes + payload) and compared with
// the bytes collected from the output handshake.
module tb_udp_tx;
  localparam int MAXP = 1472;

`ifdef UDP_TX_LEN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef bit bitq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] pkt_count;
  logic        len_err;

  udp_tx_if bus ();

  udp_tx #(.MAX_PAYLOAD(MAXP), .COUNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .pkt_count (pkt_count),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_pkt  = 0;

  // Results of the most recent drive_pkt call.
  bq_t   got_data;
  bitq_t got_last;
  int    n_rej, n_lenerr, n_inrdy, n_outvalid, stall_viol, acc_cyc, first_vcyc;

  // Reference framing: header (big-endian, length = payload + 8, zero
  // checksum) then payload; with length checking, bytes after an early
  // in_last are replaced by zero padding.
  function automatic bq_t model(input logic [15:0] s, input logic [15:0] d,
                                input logic [15:0] l, input bq_t pl, input int last_idx);
    bq_t q;
    logic [15:0] lf;
    int eff;
    lf = l + 16'd8;
    q = '{s[15:8], s[7:0], d[15:8], d[7:0], lf[15:8], lf[7:0], 8'h00, 8'h00};
    eff = (CHK && last_idx < int'(l) - 1) ? last_idx : int'(l) - 1;
    for (int i = 0; i < int'(l); i++) q.push_back(i <= eff ? pl[i] : 8'h00);
    return q;
  endfunction

  function automatic int first_diff(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic bit last_only_at_end(input bitq_t q);
    if (q.size() == 0) return 1'b0;
    foreach (q[i]) if (q[i] != (i == q.size() - 1)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // Issue one request, offer the bytes of pl (in_last on index last_idx),
  // collect everything that leaves the output. rmode: 0 ready always,
  // 1 ready pattern 1,0,0,1, 2 random. abort_after >= 0 stops once that many
  // payload bytes were accepted.
  task automatic drive_pkt(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                           input bq_t pl, input int last_idx, input int rmode,
                           input bit gaps, input int abort_after);
    int cyc = 0, idx = 0, post = 0;
    bit req_done = 0, got_fin = 0, fin = 0, prev_stall = 0, timed_out = 0;
    logic [7:0] pd = 8'h00;
    logic pdl = 1'b0;
    got_data.delete();
    got_last.delete();
    n_rej = 0; n_lenerr = 0; n_inrdy = 0; n_outvalid = 0; stall_viol = 0;
    acc_cyc = -1; first_vcyc = -1;
    while (post < 4) begin
      bus.start_valid = !req_done;
      bus.src_port    = s;
      bus.dst_port    = d;
      bus.payload_len = l;
      bus.in_valid    = (idx < pl.size()) && (!gaps || $urandom_range(0, 3) != 0);
      bus.in_data     = (idx < pl.size()) ? pl[idx] : 8'h00;
      bus.in_last     = (idx == last_idx);
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.out_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (fin) bus.out_ready = 1'b1;
      @(negedge clk);
      if (bus.start_valid && bus.start_ready) begin
        req_done = 1;
        acc_cyc  = cyc;
      end
      if (bus.start_rej) n_rej++;
      if (len_err) n_lenerr++;
      if (bus.in_ready) n_inrdy++;
      if (bus.out_valid) begin
        n_outvalid++;
        if (first_vcyc < 0) first_vcyc = cyc;
      end
      if (prev_stall && (!bus.out_valid || bus.out_data !== pd || bus.out_last !== pdl))
        stall_viol++;
      prev_stall = bus.out_valid && !bus.out_ready;
      pd  = bus.out_data;
      pdl = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        if (bus.out_last) got_fin = 1;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
      if (abort_after >= 0 && idx >= abort_after) break;
      if (fin) post++;
      else if (req_done && idx >= pl.size() && (got_fin || (cyc - acc_cyc > 20 && !busy))) fin = 1;
      if (cyc > 6000) begin
        timed_out = 1;
        break;
      end
    end
    bus.start_valid = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.out_ready   = 1'b1;
    if (timed_out) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout got_bytes=%0d required=packet end within 6000 cycles", got_data.size());
    end
    $display("txn src=%h dst=%h len=%0d out_bytes=%0d rej=%0d len_err=%0d", s, d, l,
             got_data.size(), n_rej, n_lenerr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_valid = 1'b0; bus.src_port = '0; bus.dst_port = '0; bus.payload_len = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", bus.out_last); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data got=%h exp=00", bus.out_data); end
    checks++; if (bus.start_rej !== 1'b0 || len_err !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b exp=00", bus.start_rej, len_err); end
    checks++; if (pkt_count !== 16'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_count_busy got=%0d/%b exp=0/0", pkt_count, busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.start_ready !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b%b exp=10", bus.start_ready, bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bq_t exp_q, pl;
    int fd;
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    drive_pkt(16'h1234, 16'h0050, 16'd4, pl, 3, 0, 1'b0, -1);
    exp_pkt++;
    fd = first_diff(exp_q, got_data);
    checks++; if (fd != -1) begin failures++; $display("FAIL basic_bytes got_size=%0d exp_size=12 first_diff=%0d", got_data.size(), fd); end
    checks++; if (!last_only_at_end(got_last)) begin failures++; $display("FAIL basic_last got=%p exp=last on byte 11 only", got_last); end
    checks++; if (first_vcyc - acc_cyc != 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1", first_vcyc - acc_cyc); end
    checks++; if (pkt_count !== 16'(exp_pkt)) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", pkt_count, exp_pkt); end
    checks++; if (n_lenerr != 0) begin failures++; $display("FAIL basic_len_err got=%0d exp=0", n_lenerr); end
  endtask

  task automatic test_zero_len();
    bq_t exp_q, pl;
    logic [15:0] s, d;
    int fd;
    s = 16'($urandom); d = 16'($urandom);
    exp_q = model(s, d, 16'd0, pl, -1);
    drive_pkt(s, d, 16'd0, pl, -1, 2, 1'b0, -1);
    exp_pkt++;
    fd = first_diff(exp_q, got_data);
    checks++; if (fd != -1) begin failures++; $display("FAIL zero_bytes got_size=%0d exp_size=8 first_diff=%0d", got_data.size(), fd); end
    checks++; if (!last_only_at_end(got_last)) begin failures++; $display("FAIL zero_last got=%p exp=last on byte 7 only", got_last); end
    checks++; if (n_inrdy != 0) begin failures++; $display("FAIL zero_in_ready got=%0d cycles exp=0", n_inrdy); end
    checks++; if (pkt_count !== 16'(exp_pkt)) begin failures++; $display("FAIL zero_count got=%0d exp=%0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_reject();
    bq_t exp_q, pl;
    logic [15:0] bad [2];
    int fd;
    bad[0] = 16'(MAXP + 1);
    bad[1] = 16'hFFFF;
    foreach (bad[i]) begin
      drive_pkt(16'($urandom), 16'($urandom), bad[i], pl, -1, 0, 1'b0, -1);
      checks++; if (n_rej != 1) begin failures++; $display("FAIL rej_pulse len=%0d got=%0d exp=1", bad[i], n_rej); end
      checks++; if (n_outvalid != 0) begin failures++; $display("FAIL rej_out_valid len=%0d got=%0d cycles exp=0", bad[i], n_outvalid); end
      checks++; if (pkt_count !== 16'(exp_pkt)) begin failures++; $display("FAIL rej_count got=%0d exp=%0d", pkt_count, exp_pkt); end
    end
    pl = rand_bytes(MAXP);
    exp_q = model(16'hBEEF, 16'h0035, 16'(MAXP), pl, MAXP - 1);
    drive_pkt(16'hBEEF, 16'h0035, 16'(MAXP), pl, MAXP - 1, 0, 1'b0, -1);
    exp_pkt++;
    fd = first_diff(exp_q, got_data);
    checks++; if (fd != -1 || n_rej != 0) begin failures++; $display("FAIL max_len_bytes got_size=%0d exp_size=%0d first_diff=%0d rej=%0d", got_data.size(), exp_q.size(), fd, n_rej); end
    checks++; if (pkt_count !== 16'(exp_pkt)) begin failures++; $display("FAIL max_len_count got=%0d exp=%0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_stall();
    bq_t exp_q, pl, ref_q;
    logic [15:0] s, d;
    int fd;
    s = 16'($urandom); d = 16'($urandom);
    pl = rand_bytes(3);
    exp_q = model(s, d, 16'd3, pl, 2);
    drive_pkt(s, d, 16'd3, pl, 2, 0, 1'b0, -1);
    exp_pkt++;
    ref_q = got_data;
    drive_pkt(s, d, 16'd3, pl, 2, 1, 1'b0, -1);
    exp_pkt++;
    fd = first_diff(exp_q, got_data);
    checks++; if (fd != -1) begin failures++; $display("FAIL stall_bytes got_size=%0d exp_size=11 first_diff=%0d", got_data.size(), fd); end
    fd = first_diff(ref_q, got_data);
    checks++; if (fd != -1) begin failures++; $display("FAIL stall_vs_unstalled first_diff=%0d exp=-1", fd); end
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_hold got=%0d changes exp=0", stall_viol); end
    checks++; if (!last_only_at_end(got_last)) begin failures++; $display("FAIL stall_last got=%p exp=last on final byte only", got_last); end
    checks++; if (pkt_count !== 16'(exp_pkt)) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_reset_mid();
    bq_t exp_q, pl;
    logic [15:0] s, d;
    int fd;
    pl = rand_bytes(10);
    drive_pkt(16'h1111, 16'h2222, 16'd10, pl, 9, 0, 1'b0, 2);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin failures++; $display("FAIL midrst_valid_last got=%b%b exp=00", bus.out_valid, bus.out_last); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", bus.out_data); end
    checks++; if (busy !== 1'b0 || pkt_count !== 16'd0) begin failures++; $display("FAIL midrst_busy_count got=%b/%0d exp=0/0", busy, pkt_count); end
    exp_pkt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    s = 16'($urandom); d = 16'($urandom);
    pl = rand_bytes(5);
    exp_q = model(s, d, 16'd5, pl, 4);
    drive_pkt(s, d, 16'd5, pl, 4, 2, 1'b1, -1);
    exp_pkt++;
    fd = first_diff(exp_q, got_data);
    checks++; if (fd != -1) begin failures++; $display("FAIL midrst_fresh got_size=%0d exp_size=13 first_diff=%0d", got_data.size(), fd); end
    checks++; if (pkt_count !== 16'(exp_pkt)) begin failures++; $display("FAIL midrst_count got=%0d exp=%0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_back_to_back();
    bq_t exp_q, pl;
    logic [15:0] s, d, l;
    int fd;
    for (int k = 0; k < 12; k++) begin
      s = 16'($urandom); d = 16'($urandom);
      l = 16'($urandom_range(0, 24));
      pl = rand_bytes(int'(l));
      exp_q = model(s, d, l, pl, int'(l) - 1);
      drive_pkt(s, d, l, pl, int'(l) - 1, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
      exp_pkt++;
      fd = first_diff(exp_q, got_data);
      checks++; if (fd != -1) begin failures++; $display("FAIL b2b_bytes pkt=%0d got_size=%0d exp_size=%0d first_diff=%0d", k, got_data.size(), exp_q.size(), fd); end
      checks++; if (!last_only_at_end(got_last) || stall_viol != 0) begin failures++; $display("FAIL b2b_last_hold pkt=%0d stall_changes=%0d exp=0 last=%p", k, stall_viol, got_last); end
    end
    checks++; if (pkt_count !== 16'(exp_pkt)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", pkt_count, exp_pkt); end
  endtask

`ifdef UDP_TX_LEN_CHECK_EN
  task automatic test_len_check();
    bq_t exp_q, pl;
    int fd;
    // Early last: declared 4, in_last on the second byte.
    pl = rand_bytes(2);
    exp_q = model(16'h0A0B, 16'h0C0D, 16'd4, pl, 1);
    drive_pkt(16'h0A0B, 16'h0C0D, 16'd4, pl, 1, 2, 1'b0, -1);
    exp_pkt++;
    fd = first_diff(exp_q, got_data);
    checks++; if (fd != -1) begin failures++; $display("FAIL early_bytes got_size=%0d exp_size=12 first_diff=%0d", got_data.size(), fd); end
    checks++; if (n_lenerr != 1) begin failures++; $display("FAIL early_len_err got=%0d exp=1", n_lenerr); end
    // Late last: declared 2, four bytes offered with in_last on the fourth.
    pl = rand_bytes(4);
    exp_q = model(16'h0E0F, 16'h1011, 16'd2, pl, 3);
    drive_pkt(16'h0E0F, 16'h1011, 16'd2, pl, 3, 0, 1'b1, -1);
    exp_pkt++;
    fd = first_diff(exp_q, got_data);
    checks++; if (fd != -1) begin failures++; $display("FAIL late_bytes got_size=%0d exp_size=10 first_diff=%0d", got_data.size(), fd); end
    checks++; if (n_lenerr != 1 || busy !== 1'b0) begin failures++; $display("FAIL late_len_err got=%0d busy=%b exp=1 busy=0", n_lenerr, busy); end
    checks++; if (pkt_count !== 16'(exp_pkt)) begin failures++; $display("FAIL lencheck_count got=%0d exp=%0d", pkt_count, exp_pkt); end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog got=no finish exp=finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_reject();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef UDP_TX_LEN_CHECK_EN
    test_len_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
